store_drain_ctrl: RTL and testbench

- Sequences committed stores out of the store queue into the single-ported D-cache, oldest first, one at a time.
- Arbitrates the D-cache port between the load path and store drain.
- Releases each store-queue entry only after its cache write completes.
- Sits between commit, the store queue and the D-cache controller.

---
 rtl/store_drain_ctrl_pkg.sv | 22 ++
 rtl/store_drain_ctrl_arb.sv | 48 ++++
 rtl/store_drain_ctrl.sv | 118 +++++++++++
 tb/tb_store_drain_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_drain_ctrl_pkg.sv
// Load/store sizing shared by the store drain path.
// Drain FSM encodings and SQ index/count widths.
package store_drain_ctrl_pkg;

  localparam int LSU_SQ_DEPTH     = 8;
  localparam int LSU_COMMIT_WIDTH = 2;
  localparam int LSU_ADDR_WIDTH   = 32;
  localparam int LSU_DATA_WIDTH   = 32;
  localparam int SD_HIGH_WATER    = 6;
  localparam int SD_STARVE_LIMIT  = 4;

  localparam int SQ_IDX_W     = $clog2(LSU_SQ_DEPTH);
  localparam int SQ_CNT_W     = $clog2(LSU_SQ_DEPTH + 1);
  localparam int COMMIT_CNT_W = $clog2(LSU_COMMIT_WIDTH + 1);

  typedef logic [1:0] drain_state_e;

  localparam drain_state_e IDLE = 2'd0;
  localparam drain_state_e REQ  = 2'd1;
  localparam drain_state_e WAIT = 2'd2;

endpackage

// File: rtl/store_drain_ctrl_arb.sv
// Cache-port arbitration between loads and store drain.
// Loads win by default; stores win on pressure or starvation.
module drain_port_arbiter
  import store_drain_ctrl_pkg::*;
#(
  parameter int CNT_W        = SQ_CNT_W,
  parameter int HIGH_WATER   = SD_HIGH_WATER,
  parameter int STARVE_LIMIT = SD_STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] pending_cnt,
  input  logic             ld_req_valid,
  input  logic             drain_req,
  input  logic             idle,
  output logic             store_go,
  output logic             ld_grant
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          pend_any;
  logic          high;
  logic          starved;
  logic          grant_raw;

  assign pend_any  = (pending_cnt != '0);
  assign high      = (pending_cnt >= CNT_W'(HIGH_WATER));
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
  assign store_go  = idle && pend_any &&
                     (!ld_req_valid || high || starved || drain_req);
  assign grant_raw = idle && ld_req_valid && !store_go;

  // Outputs must read 0 for the whole reset window.
  assign ld_grant = grant_raw && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (store_go) begin
      starve_cnt <= '0;
    end else if (grant_raw && pend_any && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/store_drain_ctrl.sv
// Drains committed stores to the D-cache oldest first and
// frees each store-queue entry once its write completes.
module store_drain_ctrl
  import store_drain_ctrl_pkg::*;
#(
  parameter int SQ_DEPTH      = LSU_SQ_DEPTH,
  parameter int COMMIT_WINDOW = LSU_COMMIT_WIDTH,
  parameter int ADDR_WIDTH    = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH    = LSU_DATA_WIDTH,
  parameter int HIGH_WATER    = SD_HIGH_WATER,
  parameter int STARVE_LIMIT  = SD_STARVE_LIMIT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 commit_valid,
  input  logic [$clog2(COMMIT_WINDOW+1)-1:0]   commit_store_cnt,
  input  logic                                 drain_req,
  output logic [$clog2(SQ_DEPTH)-1:0]          sq_rd_idx,
  input  logic [ADDR_WIDTH-1:0]                sq_rd_addr,
  input  logic [DATA_WIDTH-1:0]                sq_rd_data,
  input  logic                                 ld_req_valid,
  output logic                                 ld_grant,
  output logic                                 dc_req_valid,
  output logic [ADDR_WIDTH-1:0]                dc_req_addr,
  output logic [DATA_WIDTH-1:0]                dc_req_data,
  input  logic                                 dc_req_ready,
  input  logic                                 dc_wr_done,
  output logic                                 sq_free_valid,
  output logic [$clog2(SQ_DEPTH)-1:0]          sq_free_idx,
  output logic [$clog2(SQ_DEPTH+1)-1:0]        pending_cnt,
  output logic                                 drained,
  output logic                                 overflow_err
);

  localparam int IW = $clog2(SQ_DEPTH);
  localparam int CW = $clog2(SQ_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(SQ_DEPTH);

  drain_state_e  state;
  logic [IW-1:0] drain_ptr;
  logic [CW-1:0] pend_q;
  logic [SW-1:0] inc;
  logic [SW-1:0] pend_sum;
  logic          idle;
  logic          store_go;
  logic          wr_fire;

  assign idle    = (state == IDLE);
  assign wr_fire = (state == WAIT) && dc_wr_done;

  drain_port_arbiter #(
    .CNT_W        (CW),
    .HIGH_WATER   (HIGH_WATER),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .pending_cnt  (pend_q),
    .ld_req_valid (ld_req_valid),
    .drain_req    (drain_req),
    .idle         (idle),
    .store_go     (store_go),
    .ld_grant     (ld_grant)
  );

  // One bit of headroom so an over-commit is visible before clamping.
  always_comb begin
    inc = '0;
    if (commit_valid) inc = SW'(commit_store_cnt);
    pend_sum = {1'b0, pend_q} + inc - SW'(wr_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      drain_ptr    <= '0;
      pend_q       <= '0;
      overflow_err <= 1'b0;
      dc_req_addr  <= '0;
      dc_req_data  <= '0;
    end else begin
      if (pend_sum > DEPTH_S) begin
        pend_q       <= CW'(SQ_DEPTH);
        overflow_err <= 1'b1;
      end else begin
        pend_q <= pend_sum[CW-1:0];
      end
      unique case (state)
        IDLE: begin
          if (store_go) begin
            dc_req_addr <= sq_rd_addr;
            dc_req_data <= sq_rd_data;
            state       <= REQ;
          end
        end
        REQ: begin
          if (dc_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (dc_wr_done) begin
            drain_ptr <= drain_ptr + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sq_rd_idx     = drain_ptr;
  assign dc_req_valid  = (state == REQ) && (pend_q != '0);
  assign sq_free_valid = wr_fire;
  assign sq_free_idx   = wr_fire ? drain_ptr : '0;
  assign pending_cnt   = pend_q;
  assign drained       = (pend_q == '0) && idle;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Scoreboard bench for store_drain_ctrl with a
// latency-programmable D-cache responder.
module tb_store_drain_ctrl;
  import store_drain_ctrl_pkg::*;

  localparam int D  = LSU_SQ_DEPTH;
  localparam int IW = SQ_IDX_W;
  localparam int CW = SQ_CNT_W;
  localparam int KW = COMMIT_CNT_W;
  localparam int AW = LSU_ADDR_WIDTH;
  localparam int DW = LSU_DATA_WIDTH;

  typedef struct {
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } st_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          commit_valid;
  logic [KW-1:0] commit_store_cnt;
  logic          drain_req;
  logic [IW-1:0] sq_rd_idx;
  logic [AW-1:0] sq_rd_addr;
  logic [DW-1:0] sq_rd_data;
  logic          ld_req_valid;
  logic          ld_grant;
  logic          dc_req_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_data;
  logic          dc_req_ready;
  logic          dc_wr_done;
  logic          sq_free_valid;
  logic [IW-1:0] sq_free_idx;
  logic [CW-1:0] pending_cnt;
  logic          drained;
  logic          overflow_err;

  logic [AW-1:0] sq_addr_m [D];
  logic [DW-1:0] sq_data_m [D];

  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  st_t sb[$];
  int  exp_pend = 0;
  bit  exp_ovf = 0;
  bit  busy = 0;
  int  req_rise_cyc = -1;
  int  free_cyc = -1;
  int  gp_cnt = 0;
  int  gb_cnt = 0;
  int  tail = 0;
  int  rdy_lat = 0;
  int  done_lat = 1;
  bit  resp_en = 1;
  int  phase = 0;
  int  rcnt = 0;
  int  c0;
  int  dcyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sq_rd_addr = sq_addr_m[sq_rd_idx];
  assign sq_rd_data = sq_data_m[sq_rd_idx];

  store_drain_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .commit_valid     (commit_valid),
    .commit_store_cnt (commit_store_cnt),
    .drain_req        (drain_req),
    .sq_rd_idx        (sq_rd_idx),
    .sq_rd_addr       (sq_rd_addr),
    .sq_rd_data       (sq_rd_data),
    .ld_req_valid     (ld_req_valid),
    .ld_grant         (ld_grant),
    .dc_req_valid     (dc_req_valid),
    .dc_req_addr      (dc_req_addr),
    .dc_req_data      (dc_req_data),
    .dc_req_ready     (dc_req_ready),
    .dc_wr_done       (dc_wr_done),
    .sq_free_valid    (sq_free_valid),
    .sq_free_idx      (sq_free_idx),
    .pending_cnt      (pending_cnt),
    .drained          (drained),
    .overflow_err     (overflow_err)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit(input int n);
    st_t s;
    commit_valid     = 1'b1;
    commit_store_cnt = KW'(n);
    for (int i = 0; i < n; i++) begin
      s.idx  = IW'(tail);
      s.addr = AW'($urandom);
      s.data = DW'($urandom);
      sq_addr_m[tail] = s.addr;
      sq_data_m[tail] = s.data;
      sb.push_back(s);
      tail = (tail + 1) % D;
    end
    step(1);
    commit_valid     = 1'b0;
    commit_store_cnt = '0;
  endtask

  task automatic wait_drained(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drained) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) check("drain_timeout", drained, 1);
    step(1);
  endtask

  // D-cache model: ready after rdy_lat cycles of request,
  // write done done_lat cycles after acceptance.
  initial begin
    dc_req_ready = 1'b0;
    dc_wr_done   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dc_wr_done   = 1'b0;
      dc_req_ready = 1'b0;
      if (rst) begin
        phase = 0;
        rcnt  = 0;
      end else if (phase == 0) begin
        if (dc_req_valid && resp_en) begin
          if (rcnt >= rdy_lat) begin
            dc_req_ready = 1'b1;
            phase = 1;
            rcnt  = 0;
          end else begin
            rcnt++;
          end
        end
      end else begin
        if (rcnt >= done_lat) begin
          dc_wr_done = 1'b1;
          phase = 0;
          rcnt  = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    int nxt;
    if (rst) begin
      exp_pend = 0;
      exp_ovf  = 0;
      busy     = 0;
      sb.delete();
    end else begin
      check("pend", pending_cnt, exp_pend);
      check("drained", drained, exp_pend == 0);
      check("ovf", overflow_err, exp_ovf);
      if (dc_req_valid) begin
        if (!busy) begin
          busy = 1;
          req_rise_cyc = cyc;
        end
        if (sb.size() == 0) begin
          check("req_spur", dc_req_valid, 0);
        end else begin
          check("req_addr", dc_req_addr, sb[0].addr);
          check("req_data", dc_req_data, sb[0].data);
        end
      end
      if (ld_grant && busy) gb_cnt++;
      if (ld_grant && !busy && exp_pend > 0) gp_cnt++;
      if (sq_free_valid) begin
        if (sb.size() == 0) begin
          check("free_spur", sq_free_valid, 0);
        end else begin
          check("free_idx", sq_free_idx, sb[0].idx);
          void'(sb.pop_front());
        end
        busy = 0;
        free_cyc = cyc;
      end
      nxt = exp_pend
          + (commit_valid ? int'(commit_store_cnt) : 0)
          - (dc_wr_done ? 1 : 0);
      if (nxt > D) begin
        nxt = D;
        exp_ovf = 1;
      end
      exp_pend = nxt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    commit_valid     = 1'b0;
    commit_store_cnt = '0;
    drain_req        = 1'b0;
    ld_req_valid     = 1'b1;
    for (int i = 0; i < D; i++) begin
      sq_addr_m[i] = '0;
      sq_data_m[i] = '0;
    end

    // reset values, with a load request pending
    step(3);
    check("rst_drained", drained, 1);
    check("rst_pend", pending_cnt, 0);
    check("rst_req", dc_req_valid, 0);
    check("rst_free", sq_free_valid, 0);
    check("rst_ldg", ld_grant, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_idx", sq_rd_idx, 0);
    rst = 1'b0;
    step(2);
    check("idle_ldg", ld_grant, 1);
    ld_req_valid = 1'b0;
    step(1);

    // single store latency
    c0 = cyc;
    commit(1);
    wait_drained(50, dcyc);
    check("lat_req", req_rise_cyc, c0 + 2);
    check("lat_free", free_cyc, c0 + 4);
    check("lat_drained", dcyc, c0 + 5);

    // dual commits up to drain_ptr 7, then wrap
    for (int i = 0; i < 3; i++) commit(2);
    wait_drained(200, dcyc);
    check("wrap_ptr7", sq_rd_idx, 7);
    commit(2);
    wait_drained(100, dcyc);
    check("wrap_ptr1", sq_rd_idx, 1);

    // load contention forces the store after the starve limit
    ld_req_valid = 1'b1;
    gp_cnt = 0;
    gb_cnt = 0;
    commit(1);
    wait_drained(100, dcyc);
    check("starve_grants", gp_cnt, 4);
    check("starve_busy", gb_cnt, 0);

    // high water: 6 pending overrides loads immediately
    gp_cnt = 0;
    gb_cnt = 0;
    commit(2);
    commit(2);
    commit(2);
    wait_drained(400, dcyc);
    check("hw_grants", gp_cnt, 22);
    check("hw_busy", gb_cnt, 0);

    // drain_req gives stores priority throughout
    drain_req = 1'b1;
    gp_cnt = 0;
    commit(2);
    commit(1);
    wait_drained(200, dcyc);
    check("drain_grants", gp_cnt, 0);
    drain_req    = 1'b0;
    ld_req_valid = 1'b0;

    // back-pressure and a long miss, commits during the wait
    rdy_lat  = 5;
    done_lat = 20;
    commit(1);
    step(2);
    commit(2);
    wait_drained(500, dcyc);
    rdy_lat  = 0;
    done_lat = 1;

    // reset while in WAIT
    done_lat     = 30;
    ld_req_valid = 1'b1;
    commit(1);
    step(4);
    check("prerst_pend", pending_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    check("wrst_drained", drained, 1);
    check("wrst_pend", pending_cnt, 0);
    check("wrst_req", dc_req_valid, 0);
    check("wrst_free", sq_free_valid, 0);
    check("wrst_ldg", ld_grant, 0);
    check("wrst_idx", sq_rd_idx, 0);
    check("wrst_addr", dc_req_addr, 0);
    check("wrst_data", dc_req_data, 0);
    step(2);
    tail = 0;
    rst  = 1'b0;
    done_lat     = 1;
    ld_req_valid = 1'b0;
    step(2);

    // overflow with the port blocked
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) commit(2);
    commit(1);
    step(1);
    check("ovf_pend", pending_cnt, 8);
    check("ovf_flag", overflow_err, 1);
    step(5);
    check("ovf_sticky", overflow_err, 1);
    check("ovf_pend_hold", pending_cnt, 8);
    rst = 1'b1;
    #1;
    check("ovf_clear", overflow_err, 0);
    step(1);
    tail    = 0;
    rst     = 1'b0;
    resp_en = 1'b1;
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
